// File: rtl/comp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package comp_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/comp_slice.sv
// Combinational 2-bit unsigned magnitude comparator slice.
module comp_slice
  import comp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_comp_ctrl.sv
// MSB-first serial magnitude comparator: one 2-bit slice per cycle, early exit on
// the first unequal slice, start/busy/done handshake with held result flags.
module serial_comp_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSL   = WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic                   busy,
  output logic                   done,
  output logic                   AeqB,
  output logic                   AgtB,
  output logic                   AltB,
  output logic [$clog2(NSL):0]   nslice
);

  localparam int unsigned CW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int unsigned NW = $clog2(NSL) + 1;

  localparam logic [CW-1:0] CntInit = CW'(NSL - 1);
  localparam logic [NW-1:0] NslMax  = NW'(NSL);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;
  logic              lt_q, lt_d;
  logic [NW-1:0]     ns_q, ns_d;

  logic              sl_eq, sl_gt, sl_lt;

  comp_slice u_slice (
    .a  (sa_q[WIDTH-1 -: SLICE_W]),
    .b  (sb_q[WIDTH-1 -: SLICE_W]),
    .eq (sl_eq),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    ns_d    = ns_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = CntInit;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          ns_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sl_gt) begin
          gt_d    = 1'b1;
          ns_d    = NslMax - NW'(cnt_q);
          state_d = DONE;
        end else if (sl_lt) begin
          lt_d    = 1'b1;
          ns_d    = NslMax - NW'(cnt_q);
          state_d = DONE;
        end else if (cnt_q == '0) begin
          eq_d    = 1'b1;
          ns_d    = NslMax;
          state_d = DONE;
        end else begin
          sa_d    = sa_q << SLICE_W;
          sb_d    = sb_q << SLICE_W;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      ns_q    <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      ns_q    <= ns_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign AeqB   = eq_q;
  assign AgtB   = gt_q;
  assign AltB   = lt_q;
  assign nslice = ns_q;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl at WIDTH=8 with hand-computed expectations.
module tb_serial_comp_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       AeqB;
  logic       AgtB;
  logic       AltB;
  logic [2:0] nslice;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int base;

  serial_comp_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .AeqB   (AeqB),
    .AgtB   (AgtB),
    .AltB   (AltB),
    .nslice (nslice)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".eq"}, AeqB, 0);
    check({tag, ".gt"}, AgtB, 0);
    check({tag, ".lt"}, AltB, 0);
    check({tag, ".ns"}, nslice, 0);
  endtask

  // Launch one compare, measure start-to-done latency, then check result and hold.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input int exp_lat, input logic e, input logic g, input logic l,
                     input logic [2:0] ns);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'h5A;
    B = 8'hC3;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
      else begin
        check({tag, ".run_busy"}, busy, 1);
        check({tag, ".run_flags"}, {AeqB, AgtB, AltB}, 3'b000);
      end
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_done"}, busy, 1);
    check({tag, ".eq"}, AeqB, e);
    check({tag, ".gt"}, AgtB, g);
    check({tag, ".lt"}, AltB, l);
    check({tag, ".ns"}, nslice, ns);
    @(posedge clk);
    #1;
    check({tag, ".done_fall"}, done, 0);
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".hold"}, {AeqB, AgtB, AltB, nslice}, {e, g, l, ns});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run("eq_a5", 8'hA5, 8'hA5, 4, 1'b1, 1'b0, 1'b0, 3'd4);
    run("gt_c0", 8'hC0, 8'h40, 1, 1'b0, 1'b1, 1'b0, 3'd1);
    run("lt_12", 8'h12, 8'h13, 4, 1'b0, 1'b0, 1'b1, 3'd4);
    run("gt_30", 8'h30, 8'h20, 2, 1'b0, 1'b1, 1'b0, 3'd2);

    // start held through RUN and DONE with reversed operands must be ignored
    @(negedge clk);
    base = done_cnt;
    start = 1'b1;
    A = 8'h00;
    B = 8'hFF;
    @(posedge clk);
    #1;
    A = 8'hFF;
    B = 8'h00;
    @(posedge clk);
    #1;
    check("ign.done", done, 1);
    check("ign.lt", AltB, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign.busy", busy, 0);
    check("ign.done_fall", done, 0);
    check("ign.flags", {AeqB, AgtB, AltB}, 3'b001);
    run("restart", 8'hFF, 8'h00, 1, 1'b0, 1'b1, 1'b0, 3'd1);
    check("ign.pulses", done_cnt - base, 2);

    // Reset two cycles into a four-slice compare
    @(negedge clk);
    start = 1'b1;
    A = 8'h01;
    B = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid.busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check_idle_zero("mid_rst");
    base = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid.no_done", done_cnt - base, 0);
    check_idle_zero("mid_after");
    run("post_rst", 8'h01, 8'h00, 4, 1'b0, 1'b1, 1'b0, 3'd4);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold.flags", {AeqB, AgtB, AltB}, 3'b010);
      check("hold.ns", nslice, 3'd4);
      check("hold.busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
